// File: rtl/lane_slip_sched.sv
// Bitslip scheduler and lock supervisor for a multi-lane PCS receive path.
// Grants one slip at a time in round-robin order, then holds off so the gearbox can settle.
module lane_slip_sched #(
  parameter int LANES        = 4,
  parameter int SLIP_HOLDOFF = 32,
  parameter int LOCK_TIMEOUT = 65536
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LANES-1:0] slip_req,
  input  logic [LANES-1:0] block_locked,
  output logic [LANES-1:0] slip_out,
  output logic [LANES-1:0] lane_hold,
  output logic             all_locked,
  output logic [LANES-1:0] lane_resync
);

  localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int HC_W  = (SLIP_HOLDOFF > 1) ? $clog2(SLIP_HOLDOFF) : 1;
  localparam int TO_W  = $clog2(LOCK_TIMEOUT);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [LANES-1:0] slip_out_q, slip_out_d;
  logic [LANES-1:0] lane_resync_q, lane_resync_d;
  logic             all_locked_q, all_locked_d;

  logic             grant_found;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] cand;

  // Round-robin search starts just after the last granted lane, so a lane
  // that keeps requesting yields to every other requester before it wins again.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = ptr_q;
    cand        = ptr_q;
    for (int i = 1; i <= LANES; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % LANES);
      if (!grant_found && slip_req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    slip_out_d = '0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          slip_out_d = LANES'(1) << grant_idx;
          ptr_d      = grant_idx;
          hold_cnt_d = HC_W'(SLIP_HOLDOFF - 1);
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lock supervisor: any all-locked cycle restarts the timeout window.
  always_comb begin
    all_locked_d  = &block_locked;
    lane_resync_d = '0;
    to_cnt_d      = to_cnt_q;
    if (&block_locked) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_W'(LOCK_TIMEOUT - 1)) begin
      lane_resync_d = ~block_locked;
      to_cnt_d      = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= PTR_W'(LANES - 1);
      hold_cnt_q    <= '0;
      to_cnt_q      <= '0;
      slip_out_q    <= '0;
      lane_resync_q <= '0;
      all_locked_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      to_cnt_q      <= to_cnt_d;
      slip_out_q    <= slip_out_d;
      lane_resync_q <= lane_resync_d;
      all_locked_q  <= all_locked_d;
    end
  end

  assign slip_out    = slip_out_q;
  assign lane_resync = lane_resync_q;
  assign all_locked  = all_locked_q;
  assign lane_hold   = (state_q == HOLD) ? (LANES'(1) << ptr_q) : '0;

endmodule

// File: tb/tb_lane_slip_sched.sv
// Bench for lane_slip_sched: a cycle model predicts every output cycle into a
// queue that is drained and compared after each clock edge, plus directed checks.
module tb_lane_slip_sched;

  localparam int LANES        = 4;
  localparam int SLIP_HOLDOFF = 4;
  localparam int LOCK_TIMEOUT = 16;
  localparam int EW           = 3 * LANES + 1;

  logic             clk;
  logic             reset;
  logic [LANES-1:0] slip_req;
  logic [LANES-1:0] block_locked;
  logic [LANES-1:0] slip_out;
  logic [LANES-1:0] lane_hold;
  logic             all_locked;
  logic [LANES-1:0] lane_resync;

  lane_slip_sched #(
    .LANES       (LANES),
    .SLIP_HOLDOFF(SLIP_HOLDOFF),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .slip_req    (slip_req),
    .block_locked(block_locked),
    .slip_out    (slip_out),
    .lane_hold   (lane_hold),
    .all_locked  (all_locked),
    .lane_resync (lane_resync)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int            checks;
  int            errors;
  int            grants[$];
  int            resync_cnt;
  int            lane3_slips;

  // reference model state
  int m_ptr;
  int m_hold_rem;
  int m_to;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr      = LANES - 1;
    m_hold_rem = 0;
    m_to       = 0;
  endtask

  // Predict the outputs that appear after the next rising edge.
  task automatic model_push(input logic [LANES-1:0] req, input logic [LANES-1:0] bl);
    logic [LANES-1:0] n_slip;
    logic [LANES-1:0] n_hold;
    logic [LANES-1:0] n_resync;
    logic             found;
    int               idx;
    n_slip   = '0;
    n_resync = '0;
    found    = 1'b0;
    if (m_hold_rem > 0) begin
      m_hold_rem--;
    end else begin
      for (int i = 1; i <= LANES; i++) begin
        idx = (m_ptr + i) % LANES;
        if (!found && req[idx]) begin
          found       = 1'b1;
          n_slip[idx] = 1'b1;
          m_ptr       = idx;
          m_hold_rem  = SLIP_HOLDOFF;
        end
      end
    end
    n_hold = '0;
    if (m_hold_rem > 0) n_hold[m_ptr] = 1'b1;
    if (&bl) begin
      m_to = 0;
    end else begin
      m_to++;
      if (m_to == LOCK_TIMEOUT) begin
        n_resync = ~bl;
        m_to     = 0;
      end
    end
    exp_q.push_back({n_slip, n_hold, &bl, n_resync});
  endtask

  // driver: apply inputs for one cycle, predict, clock, compare
  task automatic step(input logic [LANES-1:0] req, input logic [LANES-1:0] bl);
    logic [EW-1:0] e;
    slip_req     = req;
    block_locked = bl;
    model_push(req, bl);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: queue empty, got nothing expected an entry");
    end else begin
      e = exp_q.pop_front();
      check_eq("slip_out", 32'(slip_out), 32'(e[EW-1 -: LANES]));
      check_eq("lane_hold", 32'(lane_hold), 32'(e[2*LANES : LANES+1]));
      check_eq("all_locked", 32'(all_locked), 32'(e[LANES]));
      check_eq("lane_resync", 32'(lane_resync), 32'(e[LANES-1:0]));
    end
    for (int k = 0; k < LANES; k++) begin
      if (slip_out[k]) grants.push_back(k);
    end
    if (slip_out[3]) lane3_slips++;
    if (lane_resync != '0) resync_cnt++;
  endtask

  // asynchronous reset applied mid-cycle; outputs must clear without a clock edge
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("rst_slip_out", 32'(slip_out), 32'h0);
    check_eq("rst_lane_hold", 32'(lane_hold), 32'h0);
    check_eq("rst_all_locked", 32'(all_locked), 32'h0);
    check_eq("rst_lane_resync", 32'(lane_resync), 32'h0);
    model_reset();
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    resync_cnt   = 0;
    lane3_slips  = 0;
    slip_req     = '0;
    block_locked = 4'hF;
    reset        = 1'b0;
    model_reset();

    // single requester: slips spaced SLIP_HOLDOFF+1 apart
    do_reset();
    repeat (10) step(4'b0000, 4'hF);
    grants.delete();
    repeat (12) step(4'b0100, 4'hF);
    check_eq("single_grant_count", 32'(grants.size()), 32'd3);

    // all lanes requesting: grant order 0,1,2,3,0
    do_reset();
    grants.delete();
    repeat (21) step(4'b1111, 4'hF);
    check_eq("rr_count", 32'(grants.size()), 32'd5);
    for (int i = 0; i < 5 && i < grants.size(); i++)
      check_eq("rr_order", 32'(grants[i]), 32'(i % LANES));

    // requests raised during HOLD are ignored
    do_reset();
    lane3_slips = 0;
    grants.delete();
    step(4'b0010, 4'hF);
    step(4'b0000, 4'hF);
    step(4'b1000, 4'hF);
    step(4'b1000, 4'hF);
    step(4'b0000, 4'hF);
    step(4'b0000, 4'hF);
    step(4'b0001, 4'hF);
    step(4'b0000, 4'hF);
    check_eq("hold_ignores_lane3", 32'(lane3_slips), 32'd0);
    check_eq("hold_grant_count", 32'(grants.size()), 32'd2);
    if (grants.size() == 2) check_eq("hold_next_grant", 32'(grants[1]), 32'd0);

    // timeout repeats while lanes stay unlocked
    do_reset();
    resync_cnt = 0;
    repeat (50) step(4'b0000, 4'b1011);
    check_eq("timeout_pulses", 32'(resync_cnt), 32'd3);

    // locking at cycle 20 suppresses the next pulse
    do_reset();
    resync_cnt = 0;
    repeat (20) step(4'b0000, 4'b1011);
    repeat (20) step(4'b0000, 4'hF);
    check_eq("timeout_restart", 32'(resync_cnt), 32'd1);

    // reset two cycles into a grant, then lane 0 wins first
    do_reset();
    step(4'b0100, 4'hF);
    step(4'b0000, 4'hF);
    do_reset();
    grants.delete();
    repeat (3) step(4'b1111, 4'hF);
    check_eq("post_reset_grants", 32'(grants.size()), 32'd1);
    if (grants.size() > 0) check_eq("post_reset_first", 32'(grants[0]), 32'd0);

    // lock toggling every 3 cycles never times out
    do_reset();
    resync_cnt = 0;
    for (int i = 0; i < 60; i++)
      step(4'b0000, ((i / 3) % 2 == 0) ? 4'b0111 : 4'b1111);
    check_eq("toggle_no_resync", 32'(resync_cnt), 32'd0);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 300; i++)
      step(4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
